ahb_lite_interconnect_n: RTL and testbench

//  Parametrised single-master AHB-Lite interconnect: N-way address decoder, data-phase slave mux,

---
 rtl/ahb_lite_interconnect_n.sv | 115 +++++++++++
 tb/tb_ahb_lite_interconnect_n.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_interconnect_n.sv
// Single-master AHB-Lite interconnect: N-way address decoder, data-phase response mux,
// built-in default slave answering unmapped transfers with ERROR, and a sticky error log.
module ahb_lite_interconnect_n #(
  parameter int NUM_SLAVES = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE = (NUM_SLAVES*32)'({
    32'hF000_0000, 32'hE000_0000, 32'hD000_0000, 32'hC000_0000,
    32'hB000_0000, 32'hA000_0000, 32'h9000_0000, 32'h8000_0000,
    32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK = {NUM_SLAVES{32'hF000_0000}}
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic [31:0]              HRDATA,
  output logic [NUM_SLAVES-1:0]    S_HSEL,
  input  logic [NUM_SLAVES-1:0]    S_HREADYOUT,
  input  logic [NUM_SLAVES-1:0]    S_HRESP,
  input  logic [NUM_SLAVES*32-1:0] S_HRDATA,
  output logic                     ERR_VALID,
  output logic [31:0]              ERR_ADDR,
  output logic                     ERR_WRITE,
  input  logic                     ERR_CLR,
  output logic [1:0]               ds_state_dbg
);
  // Transfer handshake: an address phase is accepted on the rising edge where HREADY=1;
  // the selected slave then owns HREADY/HRESP/HRDATA until it returns HREADY=1.
  typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_state_t;

  ds_state_t           ds_state, ds_next;
  logic                hit_def;
  logic [NUM_SLAVES:0] sel_q;
  logic                ds_ready, ds_resp;
  logic                err_start;
  logic                unused_htrans0;

  assign unused_htrans0 = HTRANS[0];
  assign ds_state_dbg   = ds_state;

  // Lowest-numbered matching slot wins when address windows overlap.
  always_comb begin
    S_HSEL  = '0;
    hit_def = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hit_def && ((HADDR & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])) begin
        S_HSEL[i] = 1'b1;
        hit_def   = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q <= {1'b1, {NUM_SLAVES{1'b0}}};
    end else if (HREADY) begin
      sel_q <= {hit_def, S_HSEL};
    end
  end

  always_comb begin
    HREADY = 1'b0;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (sel_q[NUM_SLAVES]) begin
      HREADY = ds_ready;
      HRESP  = ds_resp;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        HREADY = S_HREADYOUT[i];
        HRESP  = S_HRESP[i];
        HRDATA = S_HRDATA[i*32 +: 32];
      end
    end
  end

  // Default-slave outputs depend only on state so HREADY has no combinational loop.
  assign ds_ready  = (ds_state != DS_ERR1);
  assign ds_resp   = (ds_state != DS_IDLE);
  assign err_start = HREADY & hit_def & HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) ds_state <= DS_IDLE;
    else        ds_state <= ds_next;
  end

  always_comb begin
    ds_next = ds_state;
    case (ds_state)
      DS_IDLE: if (err_start) ds_next = DS_ERR1;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = err_start ? DS_ERR1 : DS_IDLE;
      default: ds_next = DS_IDLE;
    endcase
  end

  // A new capture overrides a coincident clear so the log never drops a fresh error.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= '0;
      ERR_WRITE <= 1'b0;
    end else if (err_start && (!ERR_VALID || ERR_CLR)) begin
      ERR_VALID <= 1'b1;
      ERR_ADDR  <= HADDR;
      ERR_WRITE <= HWRITE;
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ahb_lite_interconnect_n.sv
// Bench for ahb_lite_interconnect_n: directed bus scenarios then randomized traffic,
// each cycle compared against a transfer-level model of decode, response and error log.
module tb_ahb_lite_interconnect_n;
  localparam int N = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic          HREADY, HRESP;
  logic [31:0]   HRDATA;
  logic [N-1:0]  S_HSEL, S_HREADYOUT, S_HRESP;
  logic [N*32-1:0] S_HRDATA;
  logic          ERR_VALID, ERR_WRITE, ERR_CLR;
  logic [31:0]   ERR_ADDR;
  logic [1:0]    ds_state_dbg;

  int checks = 0;
  int failures = 0;

  // Slot 3 duplicates slot 2's region with a narrower mask, so it is always shadowed.
  logic [31:0] base_t [N] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h2000_0000};
  logic [31:0] mask_t [N] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000};
  logic [31:0] rd_val [N];

  // Model: data-phase owner (-1 default OK, 0..N-1 slot, 4 error first cycle, 5 error second).
  int          m_dp;
  logic        m_ev, m_ew;
  logic [31:0] m_ea;

  ahb_lite_interconnect_n #(
    .NUM_SLAVES (N),
    .SLV_BASE   ({32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK   ({32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000})
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .S_HSEL(S_HSEL), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA),
    .ERR_VALID(ERR_VALID), .ERR_ADDR(ERR_ADDR), .ERR_WRITE(ERR_WRITE), .ERR_CLR(ERR_CLR),
    .ds_state_dbg(ds_state_dbg)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & mask_t[i]) == base_t[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_dp = -1;
    m_ev = 1'b0;
    m_ea = '0;
    m_ew = 1'b0;
  endtask

  // One bus cycle: drive at negedge, check combinational view, advance model to the posedge.
  task automatic step(input logic [31:0] addr, input logic [1:0] trans, input logic wr,
                      input logic [3:0] rdy, input logic [3:0] rsp, input logic clr,
                      input logic rst);
    int          slot;
    logic        e_rdy, e_rsp;
    logic [31:0] e_rd;
    logic [3:0]  e_sel;
    @(negedge HCLK);
    HADDR = addr; HTRANS = trans; HWRITE = wr; ERR_CLR = clr; HRESET = rst;
    S_HREADYOUT = rdy; S_HRESP = rsp;
    for (int i = 0; i < N; i++) S_HRDATA[i*32 +: 32] = rd_val[i];
    #1;
    slot  = decode(addr);
    e_sel = (slot >= 0) ? 4'(1 << slot) : 4'h0;
    e_rd  = 32'h0;
    if (m_dp >= 0 && m_dp < N) begin
      e_rdy = rdy[m_dp];
      e_rsp = rsp[m_dp];
      e_rd  = rd_val[m_dp];
    end else begin
      e_rdy = (m_dp != 4);
      e_rsp = (m_dp >= 4);
    end
    chk("hsel", 32'(S_HSEL), 32'(e_sel));
    chk("hready", 32'(HREADY), 32'(e_rdy));
    chk("hresp", 32'(HRESP), 32'(e_rsp));
    chk("hrdata", HRDATA, e_rd);
    chk("err_valid", 32'(ERR_VALID), 32'(m_ev));
    chk("err_addr", ERR_ADDR, m_ea);
    chk("err_write", 32'(ERR_WRITE), 32'(m_ew));
    if (rst) begin
      model_reset();
    end else begin
      if (e_rdy && slot < 0 && trans[1]) begin
        if (!m_ev || clr) begin
          m_ev = 1'b1; m_ea = addr; m_ew = wr;
        end
      end else if (clr) begin
        m_ev = 1'b0;
      end
      if (e_rdy)        m_dp = (slot >= 0) ? slot : (trans[1] ? 4 : -1);
      else if (m_dp == 4) m_dp = 5;
    end
    @(posedge HCLK);
  endtask

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11, BUSY = 2'b01;

  initial begin
    for (int i = 0; i < N; i++) rd_val[i] = 32'hCAFE_0000 | 32'(i);
    HRESET = 1'b1; HADDR = '0; HTRANS = IDLE; HWRITE = 1'b0; ERR_CLR = 1'b0;
    S_HREADYOUT = '1; S_HRESP = '0; S_HRDATA = '0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hready", 32'(HREADY), 32'h1);
    chk("rst_hresp", 32'(HRESP), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_err_valid", 32'(ERR_VALID), 32'h0);

    // Mapped read to slot 2 with zero wait states.
    step(32'h2000_0010, NONSEQ, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    #1 chk("t1_hsel", 32'(S_HSEL), 32'h4);
    chk("t1_hrdata", HRDATA, 32'hCAFE_0002);
    chk("t1_hresp", 32'(HRESP), 32'h0);
    step(32'h0, IDLE, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);

    // Slot 1 stalls three cycles while the master holds a new address.
    step(32'h1000_0004, NONSEQ, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    repeat (3) step(32'h0000_0040, NONSEQ, 1'b0, 4'b1101, 4'h0, 1'b0, 1'b0);
    step(32'h0000_0040, NONSEQ, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    #1 chk("t2_hrdata_slot0", HRDATA, 32'hCAFE_0000);
    step(32'h0, IDLE, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);

    // Unmapped write: one wait then ERROR, logged.
    step(32'h9000_0000, NONSEQ, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
    #1 chk("t3_err1_hready", 32'(HREADY), 32'h0);
    chk("t3_err1_hresp", 32'(HRESP), 32'h1);
    chk("t3_err_valid", 32'(ERR_VALID), 32'h1);
    chk("t3_err_addr", ERR_ADDR, 32'h9000_0000);
    chk("t3_err_write", 32'(ERR_WRITE), 32'h1);
    step(32'h0, IDLE, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    #1 chk("t3_err2_hready", 32'(HREADY), 32'h1);
    chk("t3_err2_hresp", 32'(HRESP), 32'h1);
    step(32'h0, IDLE, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);

    // Second unmapped read keeps the first log; then clear.
    step(32'hA000_0000, NONSEQ, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    repeat (2) step(32'h0, IDLE, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    #1 chk("t4_err_addr_kept", ERR_ADDR, 32'h9000_0000);
    step(32'h0, IDLE, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0);
    #1 chk("t4_err_cleared", 32'(ERR_VALID), 32'h0);

    // IDLE/BUSY to unmapped space is OKAY; back-to-back unmapped transfers.
    step(32'hF000_0000, IDLE, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    step(32'hF000_0008, BUSY, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    #1 chk("t5_idle_hresp", 32'(HRESP), 32'h0);
    chk("t5_idle_nolog", 32'(ERR_VALID), 32'h0);
    step(32'hF000_0000, NONSEQ, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    step(32'hF000_0004, SEQ, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
    step(32'hF000_0004, SEQ, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
    #1 chk("t5_b2b_err1", 32'(HREADY), 32'h0);
    chk("t5_first_logged", ERR_ADDR, 32'hF000_0000);
    repeat (3) step(32'h0, IDLE, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);

    // Reset while the default slave is inserting its wait state.
    step(32'hB000_0000, NONSEQ, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    step(32'h0, IDLE, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1);
    #1 chk("t6_rst_hready", 32'(HREADY), 32'h1);
    chk("t6_rst_hresp", 32'(HRESP), 32'h0);
    chk("t6_rst_err_valid", 32'(ERR_VALID), 32'h0);
    step(32'h2000_1234, NONSEQ, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    #1 chk("t6_overlap_lowest", 32'(S_HSEL), 32'h4);

    // Clear coinciding with a new capture: the capture wins.
    step(32'h4000_0000, NONSEQ, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    repeat (2) step(32'h0, IDLE, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    step(32'h5000_0000, NONSEQ, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
    #1 chk("t7_clr_vs_capture_valid", 32'(ERR_VALID), 32'h1);
    chk("t7_clr_vs_capture_addr", ERR_ADDR, 32'h5000_0000);
    repeat (2) step(32'h0, IDLE, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] rdy;
      for (int i = 0; i < N; i++) begin
        rd_val[i] = $urandom;
        rdy[i]    = ($urandom_range(0, 3) != 0);
      end
      step({4'($urandom_range(0, 15)), 28'($urandom)}, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), rdy, 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
